// File: rtl/data_sram_responder_if.sv
// Request/response channel between the MEM-stage requester and the data-SRAM responder.
// master = requester (LSU/MEM stage), slave = responder.
interface data_sram_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_sram_responder.sv
// Latency-accurate data-SRAM responder: one outstanding read/byte-masked write, read-before-write.
// Optional access-fault checking enabled by defining DSRAM_ERR_CHK_EN.
module data_sram_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 1
) (
  input logic                  clk,
  input logic                  resetn,
  data_sram_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_sram_responder: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx_c;
  logic              accept_c;
  logic              fault_c;

  assign idx_c         = bus.req_addr[ADDR_W+1:2];
  assign accept_c      = bus.req_valid && (state_q == IDLE);
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;

`ifdef DSRAM_ERR_CHK_EN
  logic err_q;

  // Misaligned or out-of-array addresses fault instead of wrapping.
  assign fault_c = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:ADDR_W+2] != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (accept_c) begin
      err_q <= fault_c;
    end
  end

  assign bus.rsp_err = err_q;
`else
  logic unused_addr;

  assign fault_c     = 1'b0;
  assign unused_addr = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};
  assign bus.rsp_err = 1'b0;
`endif

  // Next-state: accept in IDLE, count down in WAIT, hold RESP until taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      if (accept_c) begin
        rdata_q <= fault_c ? '0 : mem[idx_c];
      end
    end
  end

  // Array is never reset; committed writes survive a reset.
  always_ff @(posedge clk) begin
    if (accept_c && !fault_c) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_we[b]) begin
          mem[idx_c][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: LATENCY=1 and LATENCY=3 instances against a word-array model.
// Expectations follow DSRAM_ERR_CHK_EN when it is defined for the build.
module tb_data_sram_responder;
  localparam int unsigned AW = 10;

  logic clk;
  logic resetn;

  data_sram_responder_if b1 ();
  data_sram_responder_if b3 ();

  data_sram_responder #(.ADDR_W(AW), .LATENCY(1)) u_l1 (.clk(clk), .resetn(resetn), .bus(b1.slave));
  data_sram_responder #(.ADDR_W(AW), .LATENCY(3)) u_l3 (.clk(clk), .resetn(resetn), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  longint acc_cyc [2];

  logic [31:0] mem_m [2][1024];
  bit          known [2][1024];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_fault(input logic [31:0] a);
`ifdef DSRAM_ERR_CHK_EN
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic get_vld(input bit sel);
    return sel ? b3.rsp_valid : b1.rsp_valid;
  endfunction
  function automatic logic get_rdy(input bit sel);
    return sel ? b3.req_ready : b1.req_ready;
  endfunction
  function automatic logic get_err(input bit sel);
    return sel ? b3.rsp_err : b1.rsp_err;
  endfunction
  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? b3.rsp_rdata : b1.rsp_rdata;
  endfunction

  task automatic set_req(input bit sel, input logic v, input logic [3:0] we,
                         input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      b3.req_valid = v; b3.req_we = we; b3.req_addr = a; b3.req_wdata = d;
    end else begin
      b1.req_valid = v; b1.req_we = we; b1.req_addr = a; b1.req_wdata = d;
    end
  endtask

  task automatic set_rsp_ready(input bit sel, input logic r);
    if (sel) b3.rsp_ready = r;
    else     b1.rsp_ready = r;
  endtask

  // One full transaction, entered and left at a negedge with the responder idle.
  task automatic txn(input bit sel, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int stall,
                     output logic [31:0] obs_r, output logic obs_e);
    int          idx;
    int          lat;
    bit          exp_e;
    bit          exp_k;
    logic [31:0] exp_r;
    logic [31:0] held;
    idx   = int'(addr[AW+1:2]);
    lat   = sel ? 3 : 1;
    exp_e = is_fault(addr);
    exp_k = exp_e || known[sel][idx];
    exp_r = exp_e ? 32'h0 : mem_m[sel][idx];
    if (!exp_e) begin
      for (int b = 0; b < 4; b++)
        if (we[b]) mem_m[sel][idx][8*b +: 8] = wdata[8*b +: 8];
      if (we == 4'hF) known[sel][idx] = 1'b1;
    end

    chk("req_ready_idle", 32'(get_rdy(sel)), 32'd1);
    set_req(sel, 1'b1, we, addr, wdata);
    @(posedge clk);
    @(negedge clk);
    acc_cyc[sel] = cyc;
    set_req(sel, 1'b0, 4'h0, 32'h0, 32'h0);

    // rsp_valid is first sampled high on accept edge + LATENCY.
    for (int k = 1; k <= lat; k++) begin
      chk("rsp_valid_latency", 32'(get_vld(sel)), 32'(k == lat));
      chk("req_ready_busy", 32'(get_rdy(sel)), 32'd0);
      if (k < lat) @(negedge clk);
    end

    held = get_rdata(sel);
    for (int s = 0; s < stall; s++) begin
      set_req(sel, 1'b1, 4'hF, addr ^ 32'h4, ~wdata);
      @(negedge clk);
      chk("stall_rsp_valid", 32'(get_vld(sel)), 32'd1);
      chk("stall_rdata_stable", get_rdata(sel), held);
      chk("stall_req_ready", 32'(get_rdy(sel)), 32'd0);
    end
    set_req(sel, 1'b0, 4'h0, 32'h0, 32'h0);

    obs_r = get_rdata(sel);
    obs_e = get_err(sel);
    if (exp_k) chk("rsp_rdata", obs_r, exp_r);
    chk("rsp_err", 32'(obs_e), 32'(exp_e));

    set_rsp_ready(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_rsp_ready(sel, 1'b0);
    chk("rsp_valid_after_take", 32'(get_vld(sel)), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        e;
    longint      t0;
    logic [31:0] a;
    logic [3:0]  we;
    bit          sel;
    int          w;

    set_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    b1.rsp_ready = 1'b0;
    b3.rsp_ready = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_rsp_valid", 32'(get_vld(s[0])), 32'd0);
      chk("reset_rsp_rdata", get_rdata(s[0]), 32'd0);
      chk("reset_rsp_err", 32'(get_err(s[0])), 32'd0);
    end
    resetn = 1'b1;
    @(negedge clk);

    // Directed: full write, read-back, byte strobe, backpressure (LATENCY=1).
    txn(1'b0, 4'hF, 32'h8, 32'hDEADBEEF, 0, r, e);
    txn(1'b0, 4'h0, 32'h8, 32'h0, 0, r, e);
    chk("t1_read_back", r, 32'hDEADBEEF);
    txn(1'b0, 4'b0010, 32'h8, 32'h0000AA00, 0, r, e);
    chk("t2_pre_write_data", r, 32'hDEADBEEF);
    txn(1'b0, 4'h0, 32'h8, 32'h0, 5, r, e);
    chk("t3_read_after_strobe", r, 32'hDEADAAEF);

    // Fill a working window of both arrays, plus the last word.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 64; i++)
        if (!known[s][i]) txn(s[0], 4'hF, 32'(i) << 2, $urandom, 0, r, e);
      txn(s[0], 4'hF, 32'hFFC, 32'hC0FFEE11, 0, r, e);
    end
    txn(1'b0, 4'h0, 32'hFFC, 32'h0, 0, r, e);
    chk("last_word_read", r, 32'hC0FFEE11);

    // LATENCY=3 back-to-back reads.
    txn(1'b1, 4'h0, 32'h0, 32'h0, 0, r, e);
    t0 = acc_cyc[1];
    txn(1'b1, 4'h0, 32'h4, 32'h0, 0, r, e);
    chk("t4_issue_interval", 32'(acc_cyc[1] - t0), 32'd4);

    // Reset while a read is in WAIT.
    txn(1'b1, 4'hF, 32'h10, 32'h12345678, 0, r, e);
    set_req(1'b1, 1'b1, 4'h0, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t5_req_ready_in_wait", 32'(b3.req_ready), 32'd0);
    resetn = 1'b0;
    #1;
    chk("t5_rsp_valid_in_reset", 32'(b3.rsp_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("t5_req_ready_after_reset", 32'(b3.req_ready), 32'd1);
    chk("t5_rsp_valid_after_reset", 32'(b3.rsp_valid), 32'd0);
    txn(1'b1, 4'h0, 32'h10, 32'h0, 0, r, e);
    chk("t5_reread", r, 32'h12345678);

    // Fault / wrap addresses.
    txn(1'b0, 4'hF, 32'h6, 32'hA5A5A5A5, 0, r, e);
`ifdef DSRAM_ERR_CHK_EN
    chk("t6_fault_err", 32'(e), 32'd1);
    chk("t6_fault_rdata", r, 32'd0);
`else
    chk("t6_nofault_err", 32'(e), 32'd0);
`endif
    txn(1'b0, 4'h0, 32'h4, 32'h0, 0, r, e);
    txn(1'b0, 4'h0, 32'h1000, 32'h0, 0, r, e);

    // Randomized traffic over the working window.
    for (int i = 0; i < 80; i++) begin
      sel = 1'($urandom_range(0, 1));
      w   = ($urandom_range(0, 9) == 0) ? 1023 : int'($urandom_range(0, 63));
      a   = 32'(w) << 2;
      case ($urandom_range(0, 7))
        0: a = a | 32'($urandom_range(1, 3));
        1: a = a | ($urandom << 12) | 32'h1000;
        default: ;
      endcase
      we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      txn(sel, we, a, $urandom, int'($urandom_range(0, 2)), r, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
